// File: rtl/rf_dump_if.sv
// Register-file read port plus (address, data) output stream of the dump engine.
// master: the dump engine; slave: register file / stream consumer side.
interface rf_dump_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output rf_addr, out_valid, out_addr, out_data, out_last,
    input  rf_data, out_ready
  );

  modport slave (
    input  rf_addr, out_valid, out_addr, out_data, out_last,
    output rf_data, out_ready
  );
endinterface

// File: rtl/rf_dump.sv
// Register-file dump engine: walks the register file and streams (addr, data) words.
// Define RF_DUMP_SKIP_ZERO_EN to start the walk at x1 instead of x0.
module rf_dump #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_abort,
  rf_dump_if.master     bus,
  output logic          o_busy,
  output logic          o_done
);

`ifdef RF_DUMP_SKIP_ZERO_EN
  localparam logic [AW-1:0] FIRST = AW'(1);
`else
  localparam logic [AW-1:0] FIRST = AW'(0);
`endif
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          r_busy;
  logic          r_done;

  // Single-process FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort && (r_state != S_IDLE)) begin
        // abort wins over any handshake or completion in the same cycle
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              r_idx   <= FIRST;
              r_state <= S_READ;
              r_busy  <= 1'b1;
            end
          end
          S_READ: begin
            r_data  <= bus.rf_data;
            r_addr  <= r_idx;
            r_last  <= (r_idx == LAST);
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
          S_SEND: begin
            if (bus.out_ready) begin
              r_valid <= 1'b0;
              if (r_last) begin
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_idx   <= r_idx + AW'(1);
                r_state <= S_READ;
              end
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rf_addr   = r_idx;
  assign bus.out_valid = r_valid;
  assign bus.out_addr  = r_addr;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_rf_dump.sv
// Directed self-checking bench for rf_dump: full dumps, backpressure, abort,
// ignored starts and mid-dump reset.
module tb_rf_dump;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
`ifdef RF_DUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int N = NREG - FIRST;

  logic clk, rst_n, i_start, i_abort, o_busy, o_done;
  rf_dump_if #(.AW(AW), .DW(DW)) bus ();

  logic [DW-1:0] rf_mem [NREG];
  assign bus.rf_data = (bus.rf_addr == '0) ? '0 : rf_mem[bus.rf_addr];

  rf_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(i_start),
    .i_abort(i_abort),
    .bus    (bus),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] w_addr [64];
  logic [DW-1:0] w_data [64];
  logic          w_last [64];

  function automatic logic [DW-1:0] exp_data(input int a);
    return (a == 0) ? '0 : (32'h1000_0000 + DW'(a));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a dump and collects accepted words; returns on done, stop_word or timeout.
  task automatic run_dump(input bit toggle, input int stop_word, input bit spurious,
                          output int nw, output int done_cyc, output bit timed_out,
                          output bit stopped, output int stall_err);
    int cyc, ph;
    bit prev_stall, rdy;
    logic [3:0] pat;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic pl;
    pat = 4'b1001;
    nw = 0; done_cyc = -1; timed_out = 0; stopped = 0; stall_err = 0;
    prev_stall = 0; ph = 0; pa = '0; pd = '0; pl = 1'b0;
    bus.out_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      i_start = 1'b0;
      if (prev_stall && (bus.out_addr !== pa || bus.out_data !== pd ||
                         bus.out_last !== pl || bus.out_valid !== 1'b1))
        stall_err++;
      if (o_done === 1'b1) begin
        done_cyc = cyc;
        return;
      end
      if (bus.out_valid === 1'b1 && nw == stop_word) begin
        stopped = 1;
        return;
      end
      rdy = toggle ? pat[ph % 4] : 1'b1;
      ph++;
      bus.out_ready = rdy;
      i_start = spurious && (nw == 3);
      prev_stall = (bus.out_valid === 1'b1) && !rdy;
      pa = bus.out_addr; pd = bus.out_data; pl = bus.out_last;
      if (bus.out_valid === 1'b1 && rdy) begin
        w_addr[nw] = bus.out_addr;
        w_data[nw] = bus.out_data;
        w_last[nw] = bus.out_last;
        nw++;
      end
      tick();
      cyc++;
    end
    i_start = 1'b0;
    timed_out = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; bus.out_ready = 1'b0;
    #23;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.out_addr); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.out_last); end
    total++; if (bus.rf_addr !== '0) begin bad++; $display("FAIL reset_rf_addr got=%h want=0", bus.rf_addr); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_done); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_words(input string tag, input int nw);
    total++;
    if (nw !== N) begin bad++; $display("FAIL %s_count got=%0d want=%0d", tag, nw, N); end
    for (int i = 0; i < nw && i < N; i++) begin
      total++;
      if (w_addr[i] !== AW'(FIRST + i) || w_data[i] !== exp_data(FIRST + i) ||
          w_last[i] !== (i == N - 1)) begin
        bad++;
        $display("FAIL %s_word%0d got=%h/%h/%b want=%h/%h/%b", tag, i, w_addr[i], w_data[i],
                 w_last[i], AW'(FIRST + i), exp_data(FIRST + i), (i == N - 1));
      end
    end
  endtask

  task automatic test_full_dump();
    int nw, dc, se; bit to, st;
    run_dump(1'b0, -1, 1'b0, nw, dc, to, st, se);
    total++; if (to) begin bad++; $display("FAIL full_timeout got=1 want=0"); end
    check_words("full", nw);
    total++; if (dc !== 2 * N + 1) begin bad++; $display("FAIL full_done_cycle got=%0d want=%0d", dc, 2 * N + 1); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL full_busy_at_done got=%b want=1", o_busy); end
    tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%b want=0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL full_done_width got=%b want=0", o_done); end
  endtask

  task automatic test_backpressure();
    int nw, dc, se; bit to, st;
    run_dump(1'b1, -1, 1'b0, nw, dc, to, st, se);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
    check_words("bp", nw);
    total++; if (se !== 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0", se); end
    tick();
  endtask

  task automatic test_abort();
    int nw, dc, se, seen; bit to, st;
    run_dump(1'b0, 5, 1'b0, nw, dc, to, st, se);
    total++; if (!st || nw !== 5) begin bad++; $display("FAIL abort_reach got=%0d want=5", nw); end
    i_abort = 1'b1; bus.out_ready = 1'b1;
    tick();
    i_abort = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", o_busy); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", bus.out_valid); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_done === 1'b1 || bus.out_valid === 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", seen); end
    run_dump(1'b0, -1, 1'b0, nw, dc, to, st, se);
    check_words("restart", nw);
    tick();
  endtask

  task automatic test_ignored_start();
    int nw, dc, se; bit to, st;
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b want=0", o_busy); end
    tick(); tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_start_valid got=%b want=0", bus.out_valid); end
    run_dump(1'b0, -1, 1'b1, nw, dc, to, st, se);
    check_words("busy_start", nw);
    total++; if (dc !== 2 * N + 1) begin bad++; $display("FAIL busy_start_done got=%0d want=%0d", dc, 2 * N + 1); end
    tick();
  endtask

  task automatic test_mid_reset();
    int nw, dc, se; bit to, st;
    run_dump(1'b0, 10, 1'b0, nw, dc, to, st, se);
    total++; if (!st || nw !== 10) begin bad++; $display("FAIL rst_reach got=%0d want=10", nw); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_addr !== '0 || bus.out_data !== '0 ||
                 bus.out_last !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || bus.rf_addr !== '0) begin
      bad++;
      $display("FAIL rst_async got=v%b a%h d%h l%b b%b dn%b ra%h want=all zero", bus.out_valid,
               bus.out_addr, bus.out_data, bus.out_last, o_busy, o_done, bus.rf_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_dump(1'b0, -1, 1'b0, nw, dc, to, st, se);
    check_words("post_rst", nw);
    total++; if (dc !== 2 * N + 1) begin bad++; $display("FAIL post_rst_done got=%0d want=%0d", dc, 2 * N + 1); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < int'(NREG); i++) rf_mem[i] = 32'h1000_0000 + DW'(i);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_ignored_start();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
